// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared parameters and types for the program counter generator
package pc_gen_pkg;

    localparam int PC_GEN_BTB_DEPTH = 16;
    localparam int PC_GEN_CNT_W     = 2;
    localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_FLUSH,
        NPC_MISPRED,
        NPC_HOLD,
        NPC_PRED,
        NPC_SEQ
    } npc_sel_e;

endpackage

// File: rtl/pc_gen_btb_dm.sv
// rtl/pc_gen_btb_dm.sv - direct-mapped branch target buffer with saturating direction counters
module btb_dm
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = PC_GEN_BTB_DEPTH,
    parameter int CNT_W  = PC_GEN_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    logic [DEPTH-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag    [DEPTH];
    logic [ADDR_W-1:0] r_target [DEPTH];
    logic [CNT_W-1:0]  r_cnt    [DEPTH];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_write;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_unused_lsbs;

    assign w_unused_lsbs = ^{i_lookup_addr[1:0], i_upd_pc[1:0]};

    assign w_lk_idx = i_lookup_addr[IDX_W+1:2];
    assign w_lk_tag = i_lookup_addr[ADDR_W-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign o_pred_taken  = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
    assign o_pred_target = o_pred_taken ? r_target[w_lk_idx] : '0;

    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[ADDR_W-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // Not-taken misses leave the entry alone so they cannot evict a useful branch.
    assign w_write  = i_upd_valid && (w_up_hit || i_upd_taken);

    always_comb begin
        w_cnt_next = r_cnt[w_up_idx];
        if (!w_up_hit) begin
            w_cnt_next = CNT_WEAK;
        end else if (i_upd_taken) begin
            if (r_cnt[w_up_idx] != CNT_MAX) w_cnt_next = r_cnt[w_up_idx] + CNT_W'(1);
        end else begin
            if (r_cnt[w_up_idx] != '0) w_cnt_next = r_cnt[w_up_idx] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (w_write && !w_up_hit) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; the valid bits alone gate every hit.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_cnt[w_up_idx] <= w_cnt_next;
            if (i_upd_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= i_upd_target;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with BTB-driven next-pc selection
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CPU_RESET_ADDR),
    parameter int                BTB_DEPTH  = PC_GEN_BTB_DEPTH,
    parameter int                CNT_W      = PC_GEN_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              btb_clr_i,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_taken_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    input  logic              ex_mispredict_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_recover_pc;
    logic              w_pred_taken;
    logic [ADDR_W-1:0] w_pred_target;
    npc_sel_e          w_sel;

    btb_dm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BTB_DEPTH),
        .CNT_W  (CNT_W)
    ) u_btb (
        .clk           (clk),
        .rstn          (rstn),
        .i_clr         (btb_clr_i),
        .i_lookup_addr (r_pc),
        .o_pred_taken  (w_pred_taken),
        .o_pred_target (w_pred_target),
        .i_upd_valid   (ex_valid_i),
        .i_upd_pc      (ex_pc_i),
        .i_upd_taken   (ex_taken_i),
        .i_upd_target  (ex_target_i)
    );

    assign w_recover_pc = ex_taken_i ? ex_target_i : ex_pc_i + ADDR_W'(4);

    // A resolved mispredict outranks hold so a stalled front end still drops the wrong path.
    always_comb begin
        w_sel = NPC_SEQ;
        if (flush_i)                          w_sel = NPC_FLUSH;
        else if (ex_valid_i && ex_mispredict_i) w_sel = NPC_MISPRED;
        else if (hold_i)                      w_sel = NPC_HOLD;
        else if (w_pred_taken)                w_sel = NPC_PRED;
    end

    always_comb begin
        w_pc_next = r_pc + ADDR_W'(4);
        case (w_sel)
            NPC_FLUSH:   w_pc_next = flush_pc_i;
            NPC_MISPRED: w_pc_next = w_recover_pc;
            NPC_HOLD:    w_pc_next = r_pc;
            NPC_PRED:    w_pc_next = w_pred_target;
            default:     w_pc_next = r_pc + ADDR_W'(4);
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_pc <= RESET_ADDR;
        else       r_pc <= w_pc_next;
    end

    assign pc_o          = r_pc;
    assign pred_taken_o  = w_pred_taken;
    assign pred_target_o = w_pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against an entry-level BTB model
module tb_pc_gen;

    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int IDXW  = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CWEAK = 1 << (CW - 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          hold_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [AW-1:0] flush_pc_i = '0;
    logic          btb_clr_i = 1'b0;
    logic          ex_valid_i = 1'b0;
    logic [AW-1:0] ex_pc_i = '0;
    logic          ex_taken_i = 1'b0;
    logic [AW-1:0] ex_target_i = '0;
    logic          ex_mispredict_i = 1'b0;
    logic [AW-1:0] pc_o;
    logic          pred_taken_o;
    logic [AW-1:0] pred_target_o;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W     (AW),
        .RESET_ADDR (32'h0),
        .BTB_DEPTH  (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .hold_i          (hold_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .btb_clr_i       (btb_clr_i),
        .ex_valid_i      (ex_valid_i),
        .ex_pc_i         (ex_pc_i),
        .ex_taken_i      (ex_taken_i),
        .ex_target_i     (ex_target_i),
        .ex_mispredict_i (ex_mispredict_i),
        .pc_o            (pc_o),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o)
    );

    // Reference model: each slot remembers the full address that trained it.
    logic [AW-1:0] m_pc;
    bit            m_v      [DEPTH];
    logic [AW-1:0] m_ent_pc [DEPTH];
    logic [AW-1:0] m_tgt    [DEPTH];
    int            m_cnt    [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int idx_of(logic [AW-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit m_hit(logic [AW-1:0] a);
        int i = idx_of(a);
        return m_v[i] && ((m_ent_pc[i] >> (IDXW + 2)) == (a >> (IDXW + 2)));
    endfunction

    function automatic bit m_pred(logic [AW-1:0] a);
        return m_hit(a) && (m_cnt[idx_of(a)] >= CWEAK);
    endfunction

    function automatic logic [AW-1:0] m_pred_tgt(logic [AW-1:0] a);
        return m_pred(a) ? m_tgt[idx_of(a)] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    endtask

    task automatic cycle();
        logic [AW-1:0] nxt;
        int            i;
        #1;
        chk("pc", pc_o, m_pc);
        chk("pred_taken", 32'(pred_taken_o), 32'(m_pred(m_pc)));
        chk("pred_target", pred_target_o, m_pred_tgt(m_pc));
        if (flush_i)                             nxt = flush_pc_i;
        else if (ex_valid_i && ex_mispredict_i)  nxt = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
        else if (hold_i)                         nxt = m_pc;
        else if (m_pred(m_pc))                   nxt = m_pred_tgt(m_pc);
        else                                     nxt = m_pc + 32'd4;
        if (ex_valid_i) begin
            i = idx_of(ex_pc_i);
            if (m_hit(ex_pc_i)) begin
                if (ex_taken_i) begin
                    m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                    m_tgt[i] = ex_target_i;
                end else begin
                    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (ex_taken_i) begin
                m_v[i]      = 1'b1;
                m_ent_pc[i] = ex_pc_i;
                m_tgt[i]    = ex_target_i;
                m_cnt[i]    = CWEAK;
            end
        end
        if (btb_clr_i) model_clear();
        @(posedge clk);
        #1;
        m_pc = nxt;
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        #1;
        chk("async_reset_pc", pc_o, 32'h0);
        chk("async_reset_pred", 32'(pred_taken_o), 32'h0);
        chk("async_reset_target", pred_target_o, 32'h0);
        m_pc = 32'h0;
        model_clear();
        #1;
        rstn = 1'b1;
    endtask

    task automatic train(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tgt);
        ex_valid_i = 1'b1; ex_pc_i = pc; ex_taken_i = tk; ex_target_i = tgt;
        cycle();
        ex_valid_i = 1'b0; ex_taken_i = 1'b0;
    endtask

    task automatic redirect(input logic [AW-1:0] pc);
        flush_i = 1'b1; flush_pc_i = pc;
        cycle();
        flush_i = 1'b0;
    endtask

    initial begin
        m_pc = 32'h0;
        model_clear();
        #1 rstn = 1'b0;
        #1;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_pred", 32'(pred_taken_o), 32'h0);
        #10 rstn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            chk("idle_pc", pc_o, 32'(k * 4));
            cycle();
        end

        train(32'h10, 1'b1, 32'h40);
        redirect(32'h10);
        chk("hit_taken", 32'(pred_taken_o), 32'h1);
        chk("hit_target", pred_target_o, 32'h40);
        cycle();
        chk("zero_bubble_pc", pc_o, 32'h40);

        redirect(32'h10);
        hold_i = 1'b1;
        train(32'h10, 1'b0, 32'h0);
        chk("nt1_pred", 32'(pred_taken_o), 32'h0);
        train(32'h10, 1'b0, 32'h0);
        chk("nt2_pred", 32'(pred_taken_o), 32'h0);
        chk("hold_pc", pc_o, 32'h10);

        ex_valid_i = 1'b1; ex_mispredict_i = 1'b1; ex_taken_i = 1'b0; ex_pc_i = 32'h80;
        cycle();
        chk("mispred_during_hold", pc_o, 32'h84);
        flush_i = 1'b1; flush_pc_i = 32'h200;
        cycle();
        chk("flush_over_mispred", pc_o, 32'h200);
        flush_i = 1'b0; ex_valid_i = 1'b0; ex_mispredict_i = 1'b0; hold_i = 1'b0;

        train(32'h10, 1'b1, 32'h40);
        train(32'h50, 1'b1, 32'h100);
        redirect(32'h10);
        chk("alias_miss", 32'(pred_taken_o), 32'h0);
        redirect(32'h50);
        chk("alias_new_hit", 32'(pred_taken_o), 32'h1);

        train(32'h50, 1'b1, 32'h300);
        chk("rbw_old_target", pc_o, 32'h100);
        redirect(32'h50);
        chk("rbw_new_target", pred_target_o, 32'h300);

        btb_clr_i = 1'b1;
        train(32'h20, 1'b1, 32'h44);
        btb_clr_i = 1'b0;
        redirect(32'h50);
        chk("clr_miss_old", 32'(pred_taken_o), 32'h0);
        redirect(32'h20);
        chk("clr_beats_train", 32'(pred_taken_o), 32'h0);

        train(32'h0, 1'b1, 32'h60);
        flush_i = 1'b1; flush_pc_i = 32'h500;
        reset_pulse();
        flush_i = 1'b0;
        cycle();

        redirect(32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc", pc_o, 32'h0);

        for (int n = 0; n < 500; n++) begin
            hold_i          = ($urandom % 4) == 0;
            flush_i         = ($urandom % 10) == 0;
            flush_pc_i      = 32'($urandom_range(0, 63)) << 2;
            ex_valid_i      = ($urandom % 2) == 1;
            ex_pc_i         = 32'($urandom_range(0, 63)) << 2;
            if (($urandom % 8) == 0) ex_pc_i[31:8] = 24'($urandom);
            ex_taken_i      = ($urandom % 2) == 1;
            ex_target_i     = 32'($urandom_range(0, 63)) << 2;
            ex_mispredict_i = ($urandom % 6) == 0;
            btb_clr_i       = ($urandom % 60) == 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised next-generation program counter for the Deilt_RISCV front end. It holds the fetch address and adds a direct-mapped branch target buffer (BTB) with saturating-counter direction prediction. It takes resolved-branch feedback from the execute stage for training and misprediction recovery. It sits between ctrl/ex and the instruction fetch stage, and replaces the fixed-width, predictor-less PC.

## Interface
Parameters:
- ADDR_W, 32, fetch address width in bits.
- RESET_ADDR, 0, value of pc_o after reset.
- BTB_DEPTH, 16, number of BTB entries; power of two, ≥ 2.
- CNT_W, 2, width of the saturating direction counter, ≥ 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- hold_i  in  1  fetch stall from ctrl; pc_o holds.
- flush_i  in  1  redirect from ctrl (trap/interrupt).
- flush_pc_i  in  ADDR_W  redirect target for flush_i.
- btb_clr_i  in  1  invalidate all BTB entries (fence.i).
- ex_valid_i  in  1  a branch/jump resolved in ex this cycle.
- ex_pc_i  in  ADDR_W  address of the resolved instruction.
- ex_taken_i  in  1  actual direction.
- ex_target_i  in  ADDR_W  actual taken target.
- ex_mispredict_i  in  1  fetched path was wrong; only meaningful with ex_valid_i.
- pc_o  out  ADDR_W  current fetch address (registered).
- pred_taken_o  out  1  prediction for pc_o (combinational from pc_o).
- pred_target_o  out  ADDR_W  predicted target for pc_o; 0 when pred_taken_o = 0.

## Operation
- IDX_W = log2(BTB_DEPTH). index = addr[IDX_W+1:2]. tag = addr[ADDR_W-1:IDX_W+2]. addr[1:0] is ignored.
- Each entry holds valid, tag, target[ADDR_W], and cnt[CNT_W].
- Lookup on pc_o: hit = valid and tag match. pred_taken_o = hit and cnt MSB = 1.
- Next-pc priority, highest first:
  1. flush_i → flush_pc_i.
  2. ex_valid_i & ex_mispredict_i → ex_target_i if ex_taken_i, else ex_pc_i + 4.
  3. hold_i → pc_o.
  4. pred_taken_o → pred_target_o.
  5. Otherwise → pc_o + 4.
- All address adds are modulo 2^ADDR_W: 0xFFFF_FFFC + 4 wraps to 0.
- Training when ex_valid_i = 1, independent of flush_i and hold_i:
  - Hit on ex_pc_i: cnt increments if taken, decrements if not taken, saturating at 0 and 2^CNT_W−1. If taken, target is overwritten with ex_target_i.
  - Miss and taken: allocate the entry (overwrite any existing entry). Set valid, tag, target, and cnt = 2^(CNT_W−1), i.e. weakly taken.
  - Miss and not taken: no change.
- btb_clr_i clears every valid bit at the next edge and overrides a same-cycle training write. pc_o is unaffected.
- A same-cycle lookup and update at the same index is read-before-write: the prediction uses the old entry, and the new entry is visible from the next cycle.

## Timing
- Reset (asynchronous, any time, including mid-redirect): pc_o = RESET_ADDR, all valid bits = 0, and therefore pred_taken_o = 0 and pred_target_o = 0. cnt and target contents are don't-care.
- pc_o updates on the rising clk edge after the selecting inputs. Redirect latency is 1 cycle: flush_i or a mispredict at cycle N makes pc_o the new target at N+1.
- A prediction is zero-bubble: when pred_taken_o = 1 at cycle N, pc_o = pred_target_o at N+1.
- A training write at edge N affects lookups from cycle N+1.
- hold_i does not block training or redirects. A mispredict during hold still redirects.

## Structure
- Shared defines gain `PcGenBtbDepth`, `PcGenCntW`, and `CpuResetAddr` (already present, used as the RESET_ADDR default).
- One sub-module, `btb_dm`, holds the entry arrays, the combinational lookup port, the training port, the clear logic, and the saturating-counter update. pc_gen owns the PC register and the next-pc priority mux.

## Test plan
- Reset then 3 idle cycles → pc_o = 0x0, 0x4, 0x8, 0xC; pred_taken_o = 0 throughout.
- Train a taken branch at 0x10 → 0x40, then fetch 0x10 again → pred_taken_o = 1, pred_target_o = 0x40, next pc_o = 0x40. Two not-taken trainings at 0x10 → cnt 2→1→0; the prediction falls to not-taken after the first one.
- Assert ex_valid_i, ex_mispredict_i, and ex_taken_i = 0 with ex_pc_i = 0x80 while hold_i = 1 → next pc_o = 0x84. Assert flush_i with flush_pc_i = 0x200 in the same cycle → pc_o = 0x200.
- Aliasing, BTB_DEPTH = 16: train 0x10 → 0x40, then train 0x50 taken → 0x100. Fetch 0x10 → tag miss, pred_taken_o = 0.
- Training at the currently fetched index in the same cycle → the old prediction is used. btb_clr_i → all subsequent lookups miss. rstn pulsed low mid-cycle → pc_o = RESET_ADDR immediately.
- pc_o = 0xFFFF_FFFC with no hit → next pc_o = 0x0.
